flp_sum_sequencer: RTL and testbench

//  Time-multiplexed controller for one shared FLP_adder: builds the pseudo-softmax denominator from a stream of 8-bit exponents.

---
 rtl/flp_sum_sequencer.sv | 171 +++++++++++++++++
 tb/tb_flp_sum_sequencer.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/flp_sum_sequencer.sv
// flp_sum_sequencer
//   Time-multiplexed controller for one shared FLP_adder. Folds a stream of
//   8-bit exponents (each element is 1.0*2^x) into a float accumulator, one
//   adder pass per element after the first, and presents the sum downstream.
//   Optional build macro: FLP_SEQ_SAT_EN (exponent-overflow saturation + out_sat).
module flp_sum_sequencer #(
   parameter int ADD_LAT = 1,   // cycles from stable operands to valid add_res_*
   parameter int MAX_N   = 16   // max elements per vector
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [7:0] in_data,
   input  logic       in_last,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [8:0] out_exp,
   output logic [7:0] out_mant,
`ifdef FLP_SEQ_SAT_EN
   output logic       out_sat,
`endif
   output logic [7:0] add_exp1,
   output logic [7:0] add_mant1,
   output logic [7:0] add_exp2,
   output logic [7:0] add_mant2,
   input  logic [8:0] add_res_exp,
   input  logic [7:0] add_res_mant
);

   localparam int NW = $clog2(MAX_N + 1);
   localparam int CW = (ADD_LAT > 0) ? $clog2(ADD_LAT + 1) : 1;

   typedef enum logic [1:0] {S_IDLE, S_ACC, S_WAIT, S_DONE} state_t;

   typedef struct packed {
      logic [8:0] exp;
      logic [7:0] mant;
   } flp_t;

   state_t          state, state_nx;
   flp_t            acc_q;
   flp_t            res_nx;
   logic [7:0]      b_reg;
   logic [CW-1:0]   cnt;
   logic [NW-1:0]   n;
   logic [NW-1:0]   n_inc;
   logic            last_r;
   logic            in_fire;
   logic            res_take;
   logic            close_acc;
`ifdef FLP_SEQ_SAT_EN
   logic            sat_q;
   logic            sat_hit;
`endif

   assign in_fire   = in_valid & in_ready;
   assign n_inc     = n + 1'b1;
   assign close_acc = in_last | (n_inc == NW'(MAX_N));
   assign res_take  = (state == S_WAIT) && (cnt == CW'(ADD_LAT));

   // Adder operands come straight from the registered accumulator and
   // latched element, so they stay stable for the whole WAIT window.
   // Exponent bit 8 is not fed back; the adder only sees 8-bit exponents.
   assign add_exp1  = acc_q.exp[7:0];
   assign add_mant1 = acc_q.mant;
   assign add_exp2  = b_reg;
   assign add_mant2 = 8'h00;

   // Select the value written back into the accumulator after an adder pass.
`ifdef FLP_SEQ_SAT_EN
   always_comb begin
      sat_hit = add_res_exp[8] | acc_q.exp[8];
      res_nx  = sat_hit ? flp_t'{exp: 9'h0FF, mant: 8'hFF}
                        : flp_t'{exp: add_res_exp, mant: add_res_mant};
   end
`else
   always_comb begin
      res_nx = flp_t'{exp: add_res_exp, mant: add_res_mant};
   end
`endif

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nx;
   end

   // Next-state decode.
   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE: if (in_fire) state_nx = (in_last || (MAX_N == 1)) ? S_DONE : S_ACC;
         S_ACC:  if (in_fire) state_nx = S_WAIT;
         S_WAIT: if (res_take) state_nx = last_r ? S_DONE : S_ACC;
         S_DONE: if (out_ready) state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   // Handshake and result outputs, decoded from state and forced low in reset.
   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      out_exp   = '0;
      out_mant  = '0;
      if (!rst) begin
         in_ready  = (state == S_IDLE) || (state == S_ACC);
         out_valid = (state == S_DONE);
      end
      if (out_valid) begin
         out_exp  = acc_q.exp;
         out_mant = acc_q.mant;
      end
   end

`ifdef FLP_SEQ_SAT_EN
   assign out_sat = out_valid & sat_q;
`endif

   // Accumulator, element latch and sequencing counters.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_q  <= '0;
         b_reg  <= '0;
         cnt    <= '0;
         n      <= '0;
         last_r <= 1'b0;
`ifdef FLP_SEQ_SAT_EN
         sat_q  <= 1'b0;
`endif
      end else begin
         case (state)
            S_IDLE: begin
               // First element is loaded directly: 1.0*2^x needs no add.
               if (in_fire) begin
                  acc_q <= flp_t'{exp: {1'b0, in_data}, mant: 8'h00};
                  n     <= NW'(1);
               end
            end
            S_ACC: begin
               if (in_fire) begin
                  b_reg  <= in_data;
                  last_r <= close_acc;
                  n      <= n_inc;
                  cnt    <= '0;
               end
            end
            S_WAIT: begin
               cnt <= cnt + 1'b1;
               if (res_take) begin
                  acc_q <= res_nx;
`ifdef FLP_SEQ_SAT_EN
                  if (sat_hit) sat_q <= 1'b1;
`endif
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  n <= '0;
`ifdef FLP_SEQ_SAT_EN
                  sat_q <= 1'b0;
`endif
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_flp_sum_sequencer.sv
// tb_flp_sum_sequencer
//   Scoreboard bench: stimulus pushes the expected sum (value, sat flag and
//   handshake latency) computed from an integer reference model; an
//   independent monitor pops and compares whenever out_valid&out_ready.
//   The shared adder is modelled as an exact float sum with truncation.
module tb_flp_sum_sequencer;

   localparam int ADD_LAT = 1;
   localparam int MAX_N   = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [7:0] in_data = 8'h00;
   logic       in_last = 1'b0;
   logic       out_valid;
   logic       out_ready = 1'b1;
   logic [8:0] out_exp;
   logic [7:0] out_mant;
`ifdef FLP_SEQ_SAT_EN
   logic       out_sat;
`endif
   logic [7:0] add_exp1, add_mant1, add_exp2, add_mant2;
   logic [8:0] add_res_exp;
   logic [7:0] add_res_mant;

   flp_sum_sequencer #(.ADD_LAT(ADD_LAT), .MAX_N(MAX_N)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
      .out_valid(out_valid), .out_ready(out_ready), .out_exp(out_exp), .out_mant(out_mant),
`ifdef FLP_SEQ_SAT_EN
      .out_sat(out_sat),
`endif
      .add_exp1(add_exp1), .add_mant1(add_mant1), .add_exp2(add_exp2), .add_mant2(add_mant2),
      .add_res_exp(add_res_exp), .add_res_mant(add_res_mant)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always_ff @(posedge clk) cyc <= cyc + 1;

   // Float adder model: align smaller operand, add, renormalise once, truncate.
   function automatic logic [16:0] fadd(input logic [7:0] e1, input logic [7:0] m1,
                                        input logic [7:0] e2, input logic [7:0] m2);
      logic [7:0] eb, d;
      logic [9:0] big, sml, s;
      logic [8:0] e;
      logic [7:0] m;
      if (e1 >= e2) begin
         eb = e1; d = e1 - e2; big = {2'b01, m1}; sml = {2'b01, m2};
      end else begin
         eb = e2; d = e2 - e1; big = {2'b01, m2}; sml = {2'b01, m1};
      end
      sml = (d >= 8'd10) ? 10'd0 : (sml >> d);
      s   = big + sml;
      if (s[9]) begin e = {1'b0, eb} + 9'd1; m = s[8:1]; end
      else      begin e = {1'b0, eb};        m = s[7:0]; end
      return {e, m};
   endfunction

   logic [16:0] fsum, fsum_q;
   assign fsum = fadd(add_exp1, add_mant1, add_exp2, add_mant2);
   always_ff @(posedge clk) fsum_q <= fsum;
   assign add_res_exp  = (ADD_LAT == 0) ? fsum[16:8] : fsum_q[16:8];
   assign add_res_mant = (ADD_LAT == 0) ? fsum[7:0]  : fsum_q[7:0];

   typedef struct {
      logic [8:0] e;
      logic [7:0] m;
      logic       s;
      int         lat;
      int         acyc;
   } exp_t;

   exp_t sbq[$];
   int   errors = 0;
   int   checks = 0;
   int   rdy_mode = 0;   // 0: always ready, 1: never ready, 2: random

   // Reference: the running sum as an integer scaled by 256, truncated to
   // 9 significant bits after every element.
   longint unsigned ref_s = 0;
   int              ref_n = 0;

   task automatic chk(input string nm, input longint act, input longint req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, req, cyc);
      end
   endtask

   function automatic int msb_of(input longint unsigned v);
      int p = 0;
      for (int i = 0; i < 64; i++) if (v[i]) p = i;
      return p;
   endfunction

   function automatic longint unsigned trunc9(input longint unsigned v);
      int sh = msb_of(v) - 8;
      return (v >> sh) << sh;
   endfunction

   task automatic model_beat(input logic [7:0] x, input logic last, input int acyc);
      longint unsigned xv = longint'(256) << x;
      exp_t ex;
      int   sh;
      ref_s = (ref_n == 0) ? xv : trunc9(ref_s + xv);
      ref_n++;
      if (last || ref_n == MAX_N) begin
         sh     = msb_of(ref_s) - 8;
         ex.e   = 9'(sh);
         ex.m   = 8'(ref_s >> sh);
         ex.s   = 1'b0;
         ex.lat = (ref_n == 1) ? 1 : ADD_LAT + 2;
         ex.acyc = acyc;
         sbq.push_back(ex);
         ref_n = 0;
      end
   endtask

   // Offer one beat (called #1 after a rising edge); returns after acceptance.
   task automatic send(input logic [7:0] x, input logic last, input bit use_model,
                       output int acyc);
      int  t = 0;
      bit  ok = 0;
      in_valid = 1'b1; in_data = x; in_last = last;
      acyc = 0;
      while (!ok && t < 200) begin
         @(negedge clk);
         if (in_ready) begin ok = 1; acyc = cyc; end
         t++;
      end
      if (!ok) chk("accept_timeout", 0, 1);
      else if (use_model) model_beat(x, last, acyc);
      @(posedge clk); #1;
      in_valid = 1'b0; in_last = 1'b0;
   endtask

   task automatic beat(input logic [7:0] x, input logic last);
      int a;
      send(x, last, 1'b1, a);
   endtask

   task automatic drain();
      int t = 0;
      while (sbq.size() != 0 && t < 500) begin @(negedge clk); t++; end
      chk("drain_pending", sbq.size(), 0);
      @(posedge clk); #1;
   endtask

   // out_ready driver.
   initial begin
      forever begin
         @(posedge clk); #1;
         case (rdy_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'b0;
            default: out_ready = 1'($urandom_range(0, 1));
         endcase
      end
   end

   // Monitor: compare on every output handshake, check hold while stalled.
   initial begin
      bit         vld_d = 0, stall_d = 0;
      int         rise = 0;
      logic [16:0] held = '0;
      exp_t       ex;
      forever begin
         @(negedge clk);
         if (rst) begin vld_d = 0; stall_d = 0; continue; end
         if (out_valid) begin
            if (!vld_d) rise = cyc;
            chk("in_ready_in_done", in_ready, 0);
            if (stall_d) chk("hold_stable", {out_exp, out_mant}, held);
            if (out_ready) begin
               if (sbq.size() == 0) chk("unexpected_out", 1, 0);
               else begin
                  ex = sbq.pop_front();
                  chk("out_exp", out_exp, ex.e);
                  chk("out_mant", out_mant, ex.m);
                  chk("latency", rise - ex.acyc, ex.lat);
`ifdef FLP_SEQ_SAT_EN
                  chk("out_sat", out_sat, ex.s);
`endif
               end
            end
            held    = {out_exp, out_mant};
            stall_d = !out_ready;
         end else begin
            stall_d = 0;
         end
         vld_d = out_valid;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int   a, len;
      logic [7:0] x;
      logic lst;
`ifdef FLP_SEQ_SAT_EN
      exp_t sx;
`endif
      // Reset state.
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_exp", out_exp, 0);
      chk("rst_add_exp1", add_exp1, 0);
      chk("rst_add_mant1", add_mant1, 0);
      chk("rst_add_exp2", add_exp2, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("idle_in_ready", in_ready, 1);
      @(posedge clk); #1;

      // Single beat, pairs, mixed exponents, four equal beats.
      beat(8'd9, 1'b1);
      beat(8'd3, 1'b0); beat(8'd3, 1'b1);
      beat(8'd4, 1'b0); beat(8'd3, 1'b1);
      beat(8'd5, 1'b0); beat(8'd5, 1'b0); beat(8'd5, 1'b0); beat(8'd5, 1'b1);
      drain();

      // Output back-pressure for 10 cycles with a beat waiting.
      rdy_mode = 1;
      beat(8'd7, 1'b1);
      fork
         begin repeat (10) @(posedge clk); rdy_mode = 0; end
      join_none
      beat(8'd2, 1'b1);
      drain();

      // MAX_N closes the vector without in_last.
      for (int i = 0; i < 8; i++) beat(8'd2, 1'b0);
      drain();

      // Reset while the adder pass is in flight.
      beat(8'd3, 1'b0); beat(8'd3, 1'b0);
      rst = 1'b1; #1;
      chk("midrst_out_valid", out_valid, 0);
      chk("midrst_in_ready", in_ready, 0);
      ref_n = 0;
      @(posedge clk); #1;
      rst = 1'b0;
      beat(8'd1, 1'b1);
      drain();

`ifdef FLP_SEQ_SAT_EN
      send(8'hFF, 1'b0, 1'b0, a);
      send(8'hFF, 1'b1, 1'b0, a);
      sx.e = 9'h0FF; sx.m = 8'hFF; sx.s = 1'b1; sx.lat = ADD_LAT + 2; sx.acyc = a;
      sbq.push_back(sx);
      drain();
      beat(8'd1, 1'b1);
      drain();
`endif

      // Random vectors, random gaps and random output back-pressure.
      rdy_mode = 2;
      for (int v = 0; v < 40; v++) begin
         len = $urandom_range(1, 6);
         for (int i = 0; i < len; i++) begin
            x   = 8'($urandom_range(0, 40));
            lst = (i == len - 1) && ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 3) == 0) begin
               repeat ($urandom_range(1, 3)) @(posedge clk);
               #1;
            end
            beat(x, lst);
         end
      end
      if (ref_n != 0) beat(8'd6, 1'b1);
      rdy_mode = 0;
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
